// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, LSB-first data, optional even parity.
// Define UART_RX_PARITY_EN to compile in the PARITY state; otherwise parity_err is tied low.
module uart_rx #(
    parameter int DATA_BIT_COUNT   = 8,
    parameter int PARITY_BIT_COUNT = 0,
    parameter int STOP_BIT_COUNT   = 1,
    parameter int CLK_PER_BIT      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      serial,
    output logic [DATA_BIT_COUNT-1:0] data,
    output logic                      data_valid,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      parity_err
);

    localparam int BIT_MAX   = (DATA_BIT_COUNT > STOP_BIT_COUNT) ? DATA_BIT_COUNT : STOP_BIT_COUNT;
    localparam int CLK_CNT_W = $clog2(CLK_PER_BIT);
    localparam int BIT_CNT_W = $clog2(BIT_MAX);

    localparam logic [CLK_CNT_W-1:0] HALF_LAST = CLK_CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CLK_CNT_W-1:0] FULL_LAST = CLK_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BIT_COUNT - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BIT_COUNT - 1);

    if (DATA_BIT_COUNT < 5 || DATA_BIT_COUNT > 9) begin : g_bad_data_bits
        $error("uart_rx: DATA_BIT_COUNT must be 5..9");
    end
    if (PARITY_BIT_COUNT < 0 || PARITY_BIT_COUNT > 1) begin : g_bad_parity_bits
        $error("uart_rx: PARITY_BIT_COUNT must be 0 or 1");
    end
    if (STOP_BIT_COUNT < 1 || STOP_BIT_COUNT > 2) begin : g_bad_stop_bits
        $error("uart_rx: STOP_BIT_COUNT must be 1 or 2");
    end
    if (CLK_PER_BIT < 4) begin : g_bad_clk_per_bit
        $error("uart_rx: CLK_PER_BIT must be at least 4");
    end
`ifdef UART_RX_PARITY_EN
    if (PARITY_BIT_COUNT == 1 && DATA_BIT_COUNT > 8) begin : g_bad_parity_width
        $error("uart_rx: parity requires DATA_BIT_COUNT <= 8");
    end
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_sync;
    logic [CLK_CNT_W-1:0]      r_clk_cnt;
    logic [BIT_CNT_W-1:0]      r_bit_cnt;
    logic [DATA_BIT_COUNT-1:0] r_shift;
    logic                      r_stop_bad;
    logic                      w_rx;
    logic                      w_par_bad;

    assign w_rx = r_sync[1];
    assign busy = (r_state != S_IDLE);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sync     <= 2'b11;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_stop_bad <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[0], serial};
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                    end
                end

                S_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[DATA_BIT_COUNT-1:1]};
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt  <= '0;
                            r_stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            r_par_bad  <= 1'b0;
                            r_state    <= (PARITY_BIT_COUNT != 0) ? S_PARITY : S_STOP;
`else
                            r_state    <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: data plus parity bit must hold an even number of ones.
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        r_par_bad <= ^{w_rx, r_shift};
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= '0;
                            if (r_stop_bad || !w_rx) begin
                                frame_err  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err <= w_par_bad;
`endif
                                r_state    <= S_WAIT_IDLE;
                            end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                                parity_err <= 1'b1;
`endif
                                r_state    <= S_IDLE;
                            end else begin
                                data       <= r_shift;
                                data_valid <= 1'b1;
                                r_state    <= S_IDLE;
                            end
                        end else begin
                            r_stop_bad <= r_stop_bad | ~w_rx;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (w_rx) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized and directed frames, scoreboard queue and output monitor.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic          dv;
        logic          fe;
        logic          pe;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          serial = 1'b1;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          busy;
    logic          frame_err;
    logic          parity_err;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cycle    = 0;
    int            dv_prev  = -1;
    int            dv_last  = -1;
    logic [DW-1:0] model_last = '0;

    uart_rx #(
        .DATA_BIT_COUNT  (DW),
        .PARITY_BIT_COUNT(PB),
        .STOP_BIT_COUNT  (1),
        .CLK_PER_BIT     (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial    (serial),
        .data      (data),
        .data_valid(data_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (data_valid || frame_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got dv/fe/pe=%b%b%b, required no pulse (t=%0t)",
                         data_valid, frame_err, parity_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_flags", {data_valid, frame_err, parity_err}, {e.dv, e.fe, e.pe});
                check("event_data", data, e.data);
            end
            if (data_valid) begin
                dv_prev = dv_last;
                dv_last = cycle;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input bit chk_busy);
        serial = b;
        if (chk_busy) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("busy_in_frame", busy, 1);
            repeat (CPB - 4) @(posedge clk);
            #1;
        end else begin
            tick(CPB);
        end
    endtask

    // Reference model: the outcome of a frame follows directly from its bits.
    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop, input bit chk_busy);
        exp_t e;
        e.fe = ~stop;
        e.pe = (PB == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
        e.dv = !e.fe && !e.pe;
        if (e.dv) model_last = d;
        e.data = model_last;
        exp_q.push_back(e);
        drive_bit(1'b0, chk_busy);
        for (int i = 0; i < DW; i++) drive_bit(d[i], chk_busy);
        if (PB == 1) drive_bit(pbit, chk_busy);
        drive_bit(stop, chk_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        logic          pbit;
        logic          stop;
        int            gap;

        rst_n  = 1'b0;
        serial = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", data, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        rst_n = 1'b1;
        tick(5);

        // Single good frame, busy observed in every bit.
        send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1);
        tick(2 * CPB);
        check("data_A5", data, 8'hA5);

        // Two-cycle glitch while idle.
        serial = 1'b0;
        tick(2);
        serial = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_clear", busy, 0);
        tick(4 * CPB);
        check("glitch_data_kept", data, 8'hA5);

        // Bad stop bit followed by a break.
        send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
        tick(40);
        @(negedge clk);
        check("break_busy_held", busy, 1);
        tick(1);
        serial = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("break_released_idle", busy, 0);
        check("break_data_kept", data, 8'hA5);
        tick(2 * CPB);

        // Back-to-back frames.
        send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
        send_frame(8'hEE, ^8'hEE, 1'b1, 1'b0);
        tick(2 * CPB);
        check("b2b_spacing", dv_last - dv_prev, (1 + DW + PB + 1) * CPB);
        check("b2b_data", data, 8'hEE);

        // Reset during data bit 3, then a fresh frame.
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        serial = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 0);
        check("midrst_outputs", {data_valid, busy, frame_err, parity_err}, 0);
        model_last = '0;
        serial = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * CPB);
        check("post_rst_idle", busy, 0);
        send_frame(8'h5A, ^8'h5A, 1'b1, 1'b0);
        tick(2 * CPB);
        check("data_5A", data, 8'h5A);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        tick(2 * CPB);
        check("parity_bad_data_kept", data, 8'h5A);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        tick(2 * CPB);
        check("parity_good_data", data, 8'h01);
`endif

        // Randomized frames with occasional bad stop/parity bits and random gaps.
        for (int n = 0; n < 24; n++) begin
            d    = DW'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pbit = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            send_frame(d, pbit, stop, 1'b0);
            if (!stop) begin
                serial = 1'b1;
                tick(CPB);
            end else begin
                gap = $urandom_range(0, 20);
                if (gap > 0) tick(gap);
            end
        end

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        tick(2 * CPB);
        check("queue_drained", exp_q.size(), 0);
        check("final_data", data, model_last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
